// File: rtl/flist_arb_pkg.sv
// Shared types for the free-list arbiter: FSM state encoding and request class.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package flist_arb_pkg;

    // One flist transaction at a time walks INIT/IDLE -> xREQ -> xWAIT -> RESP -> IDLE.
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_AREQ  = 3'd2,
        ST_AWAIT = 3'd3,
        ST_DREQ  = 3'd4,
        ST_DWAIT = 3'd5,
        ST_RESP  = 3'd6
    } state_t;

    typedef enum logic {
        CLS_ALLOC   = 1'b0,
        CLS_DEALLOC = 1'b1
    } cls_t;

    // Class selection: alternate when both classes pend, otherwise take whichever pends.
    function automatic cls_t pick_cls(input logic a_any, input logic d_any, input cls_t last);
        cls_t res;
        res = CLS_DEALLOC;
        if (a_any && d_any) begin
            if (last == CLS_ALLOC) res = CLS_DEALLOC;
            else                   res = CLS_ALLOC;
        end else if (a_any) begin
            res = CLS_ALLOC;
        end
        return res;
    endfunction

endpackage

// File: rtl/flist_arb_rr_arb.sv
// Round-robin picker: combinational grant index, search starts one past the last winner.
// Latency: grant is combinational from req; pointer advances on the clock edge where en=1.
// Backpressure: none; the caller pulses en only when it actually consumes the grant.
module rr_arb #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             en,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    logic [IDX_W-1:0] r_ptr;
    int               w_cand;

    // Scan ptr+1, ptr+2, ... wrapping past N-1 to 0; first requester wins.
    always_comb begin
        any     = 1'b0;
        gnt_idx = r_ptr;
        w_cand  = 0;
        for (int k = 1; k <= N; k++) begin
            w_cand = int'(r_ptr) + k;
            if (w_cand >= N) w_cand = w_cand - N;
            if (!any && req[w_cand[IDX_W-1:0]]) begin
                any     = 1'b1;
                gnt_idx = w_cand[IDX_W-1:0];
            end
        end
    end

    // Remember the last winner so it has lowest priority next time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (en) begin
            r_ptr <= gnt_idx;
        end
    end

endmodule

// File: rtl/flist_arb.sv
// Shares one free-list allocator among N_REQ clients, one flist transaction in flight.
// Latency: IDLE grant -> flist req next cycle; flist ack -> client ack 1 cycle later.
// Backpressure: clients hold level reqs until acked; flist stalls by withholding its ack.
module flist_arb
    import flist_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 8,
    parameter int IDX_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      cli_alloc_req,
    output logic [N_REQ-1:0]      cli_alloc_ack,
    output logic [ID_W-1:0]       cli_alloc_id,
    input  logic [N_REQ-1:0]      cli_dealloc_req,
    input  logic [N_REQ*ID_W-1:0] cli_dealloc_id,
    output logic [N_REQ-1:0]      cli_dealloc_ack,
    output logic                  fl_alloc_req,
    input  logic                  fl_alloc_ack,
    input  logic [ID_W-1:0]       fl_alloc_id,
    output logic                  fl_dealloc_req,
    output logic [ID_W-1:0]       fl_dealloc_id,
    input  logic                  fl_dealloc_ack,
    input  logic                  fl_init_done,
    output logic                  busy,
    output logic                  err_spurious
);

    state_t           r_state;
    state_t           w_nxt;
    cls_t             r_cls;
    cls_t             r_last_cls;
    cls_t             w_pick;
    logic [IDX_W-1:0] r_owner;
    logic [ID_W-1:0]  r_dealloc_id;
    logic [ID_W-1:0]  r_alloc_id;
    logic             r_err;
    logic             r_busy;

    logic [IDX_W-1:0] w_a_gnt;
    logic [IDX_W-1:0] w_d_gnt;
    logic             w_a_any;
    logic             w_d_any;
    logic             w_grant;
    logic             w_a_en;
    logic             w_d_en;
    logic [IDX_W-1:0] w_grant_idx;
    logic [ID_W-1:0]  w_sel_dealloc_id;
    logic             w_spur;
    logic             w_resp_a;
    logic             w_resp_d;
    logic [N_REQ-1:0] w_owner_oh;

    rr_arb #(.N(N_REQ), .IDX_W(IDX_W)) u_rr_alloc (
        .clk     (clk),
        .rst     (rst),
        .req     (cli_alloc_req),
        .en      (w_a_en),
        .gnt_idx (w_a_gnt),
        .any     (w_a_any)
    );

    rr_arb #(.N(N_REQ), .IDX_W(IDX_W)) u_rr_dealloc (
        .clk     (clk),
        .rst     (rst),
        .req     (cli_dealloc_req),
        .en      (w_d_en),
        .gnt_idx (w_d_gnt),
        .any     (w_d_any)
    );

    // Grant decision is only taken in IDLE; INIT ignores client requests entirely.
    assign w_pick           = pick_cls(w_a_any, w_d_any, r_last_cls);
    assign w_grant          = (r_state == ST_IDLE) && (w_a_any || w_d_any);
    assign w_a_en           = w_grant && (w_pick == CLS_ALLOC);
    assign w_d_en           = w_grant && (w_pick == CLS_DEALLOC);
    assign w_grant_idx      = (w_pick == CLS_ALLOC) ? w_a_gnt : w_d_gnt;
    assign w_sel_dealloc_id = cli_dealloc_id[int'(w_d_gnt) * ID_W +: ID_W];

    // Any flist ack that does not match the state waiting for it is an error.
    assign w_spur = (fl_alloc_ack && (r_state != ST_AWAIT)) ||
                    (fl_dealloc_ack && (r_state != ST_DWAIT));

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_INIT:  if (fl_init_done) w_nxt = ST_IDLE;
            ST_IDLE: begin
                if (w_grant) begin
                    if (w_pick == CLS_ALLOC) w_nxt = ST_AREQ;
                    else                     w_nxt = ST_DREQ;
                end
            end
            ST_AREQ:  w_nxt = ST_AWAIT;
            ST_AWAIT: if (fl_alloc_ack) w_nxt = ST_RESP;
            ST_DREQ:  w_nxt = ST_DWAIT;
            ST_DWAIT: if (fl_dealloc_ack) w_nxt = ST_RESP;
            ST_RESP:  w_nxt = ST_IDLE;
            default:  w_nxt = ST_INIT;
        endcase
    end

    // Transaction context: owner/class on grant, flist ID on ack, class history on response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner      <= '0;
            r_cls        <= CLS_ALLOC;
            r_last_cls   <= CLS_DEALLOC;
            r_dealloc_id <= '0;
            r_alloc_id   <= '0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_busy <= (w_nxt != ST_IDLE);
            if (w_spur) begin
                r_err <= 1'b1;
            end
            if (w_grant) begin
                r_owner <= w_grant_idx;
                r_cls   <= w_pick;
                if (w_pick == CLS_DEALLOC) begin
                    r_dealloc_id <= w_sel_dealloc_id;
                end
            end
            if ((r_state == ST_AWAIT) && fl_alloc_ack) begin
                r_alloc_id <= fl_alloc_id;
            end
            if (r_state == ST_RESP) begin
                r_last_cls <= r_cls;
            end
        end
    end

    // Outputs are decoded from registered state only, never straight from inputs.
    assign w_owner_oh      = {{(N_REQ-1){1'b0}}, 1'b1} << r_owner;
    assign w_resp_a        = (r_state == ST_RESP) && (r_cls == CLS_ALLOC);
    assign w_resp_d        = (r_state == ST_RESP) && (r_cls == CLS_DEALLOC);
    assign cli_alloc_ack   = w_resp_a ? w_owner_oh : '0;
    assign cli_alloc_id    = w_resp_a ? r_alloc_id : '0;
    assign cli_dealloc_ack = w_resp_d ? w_owner_oh : '0;
    assign fl_alloc_req    = (r_state == ST_AREQ);
    assign fl_dealloc_req  = (r_state == ST_DREQ);
    assign fl_dealloc_id   = r_dealloc_id;
    assign busy            = r_busy;
    assign err_spurious    = r_err;

endmodule

// File: tb/tb_flist_arb.sv
// Directed bench for flist_arb with a scoreboard of expected client responses.
// Latency: checks flist-req timing after init and 1-cycle ack turnaround.
// Backpressure: bench plays both the clients and the flist, varying flist ack delay.
module tb_flist_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cli_alloc_req;
    logic [3:0]  cli_alloc_ack;
    logic [7:0]  cli_alloc_id;
    logic [3:0]  cli_dealloc_req;
    logic [31:0] cli_dealloc_id;
    logic [3:0]  cli_dealloc_ack;
    logic        fl_alloc_req;
    logic        fl_alloc_ack;
    logic [7:0]  fl_alloc_id;
    logic        fl_dealloc_req;
    logic [7:0]  fl_dealloc_id;
    logic        fl_dealloc_ack;
    logic        fl_init_done;
    logic        busy;
    logic        err_spurious;

    typedef struct {
        logic       cls;   // 0 alloc, 1 dealloc
        int         idx;
        logic [7:0] id;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    flist_arb #(.N_REQ(4), .ID_W(8), .IDX_W(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .cli_alloc_req   (cli_alloc_req),
        .cli_alloc_ack   (cli_alloc_ack),
        .cli_alloc_id    (cli_alloc_id),
        .cli_dealloc_req (cli_dealloc_req),
        .cli_dealloc_id  (cli_dealloc_id),
        .cli_dealloc_ack (cli_dealloc_ack),
        .fl_alloc_req    (fl_alloc_req),
        .fl_alloc_ack    (fl_alloc_ack),
        .fl_alloc_id     (fl_alloc_id),
        .fl_dealloc_req  (fl_dealloc_req),
        .fl_dealloc_id   (fl_dealloc_id),
        .fl_dealloc_ack  (fl_dealloc_ack),
        .fl_init_done    (fl_init_done),
        .busy            (busy),
        .err_spurious    (err_spurious)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [3:0] oh(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return one << i;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk(tag, 32'({cli_alloc_ack, cli_dealloc_ack, cli_alloc_id, fl_alloc_req,
                      fl_dealloc_req, fl_dealloc_id, busy, err_spurious}), 32'd0);
    endtask

    task automatic wait_freq(input logic dealloc, input string tag, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if ((dealloc ? fl_dealloc_req : fl_alloc_req) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk({tag, "_freq_timeout"}, 32'(dealloc ? fl_dealloc_req : fl_alloc_req), 32'd1);
    endtask

    // Acts as the flist for one transaction, then checks the client response against the scoreboard.
    task automatic fl_serve(input logic dealloc, input logic [7:0] id, input int lat, input string tag);
        logic ok;
        exp_t e;
        wait_freq(dealloc, tag, ok);
        if (!ok) return;
        if (dealloc && sb.size() > 0) chk({tag, "_fl_dealloc_id"}, 32'(fl_dealloc_id), 32'(sb[0].id));
        for (int i = 0; i < lat; i++) begin
            tick();
            chk({tag, "_wait_quiet"}, 32'({fl_alloc_req, fl_dealloc_req, cli_alloc_ack, cli_dealloc_ack}), 32'd0);
            if (dealloc && sb.size() > 0) chk({tag, "_id_hold"}, 32'(fl_dealloc_id), 32'(sb[0].id));
        end
        if (dealloc) begin
            fl_dealloc_ack = 1'b1;
        end else begin
            fl_alloc_ack = 1'b1;
            fl_alloc_id  = id;
        end
        tick();
        fl_alloc_ack   = 1'b0;
        fl_dealloc_ack = 1'b0;
        fl_alloc_id    = 8'h00;
        if (sb.size() == 0) begin
            chk({tag, "_unexpected_ack"}, 32'({cli_alloc_ack, cli_dealloc_ack}), 32'd0);
            return;
        end
        e = sb.pop_front();
        if (e.cls) begin
            chk({tag, "_dealloc_ack"}, 32'({cli_alloc_ack, cli_dealloc_ack}), 32'({4'b0000, oh(e.idx)}));
            cli_dealloc_req[e.idx] = 1'b0;
        end else begin
            chk({tag, "_alloc_ack"}, 32'({cli_alloc_ack, cli_dealloc_ack}), 32'({oh(e.idx), 4'b0000}));
            chk({tag, "_alloc_id"}, 32'(cli_alloc_id), 32'(e.id));
            cli_alloc_req[e.idx] = 1'b0;
        end
        tick();
        chk({tag, "_ack_pulse"}, 32'({cli_alloc_ack, cli_dealloc_ack}), 32'd0);
    endtask

    initial begin
        int   bad;
        logic ok;
        exp_t e;

        rst             = 1'b1;
        cli_alloc_req   = 4'b0000;
        cli_dealloc_req = 4'b0000;
        cli_dealloc_id  = {8'hA5, 8'h3C, 8'h00, 8'h00};
        fl_alloc_ack    = 1'b0;
        fl_alloc_id     = 8'h00;
        fl_dealloc_ack  = 1'b0;
        fl_init_done    = 1'b0;
        tick();
        tick();
        chk_all_zero("reset_outputs");
        rst = 1'b0;

        // Step 1: requests are ignored until the flist reports init done.
        cli_alloc_req = 4'b0001;
        e = '{cls: 1'b0, idx: 0, id: 8'h05};
        sb.push_back(e);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (fl_alloc_req || fl_dealloc_req || (|cli_alloc_ack) || (|cli_dealloc_ack)) bad++;
        end
        chk("t1_init_quiet", 32'(bad), 32'd0);
        chk("t1_busy_init", 32'(busy), 32'd1);
        fl_init_done = 1'b1;
        tick();
        chk("t1_freq_early", 32'(fl_alloc_req), 32'd0);
        tick();
        chk("t1_freq_2cyc", 32'(fl_alloc_req), 32'd1);

        // Step 2: flist answers id 05 three cycles after the request.
        fl_serve(1'b0, 8'h05, 3, "t2");
        chk("t2_idle_busy", 32'(busy), 32'd0);

        // Lone client 3 alloc moves the alloc pointer to 3.
        cli_alloc_req[3] = 1'b1;
        e = '{cls: 1'b0, idx: 3, id: 8'h11};
        sb.push_back(e);
        fl_serve(1'b0, 8'h11, 1, "pre3");

        // Step 3: all four clients request; each re-requests once after its first ack.
        cli_alloc_req = 4'b1111;
        for (int r = 0; r < 8; r++) begin
            if (r >= 1 && r <= 4) cli_alloc_req[(r - 1) % 4] = 1'b1;
            e = '{cls: 1'b0, idx: r % 4, id: 8'(8'h20 + r)};
            sb.push_back(e);
            fl_serve(1'b0, 8'(8'h20 + r), 1 + (r % 3), $sformatf("t3_r%0d", r));
        end

        // Step 6: wrong-type ack during AWAIT, then reset mid-transaction.
        cli_alloc_req[2] = 1'b1;
        wait_freq(1'b0, "t6", ok);
        tick();
        fl_dealloc_ack = 1'b1;
        tick();
        fl_dealloc_ack = 1'b0;
        chk("t6_wrongtype_err", 32'(err_spurious), 32'd1);
        chk("t6_wrongtype_noack", 32'({cli_alloc_ack, cli_dealloc_ack, fl_alloc_req}), 32'd0);
        #2;
        rst          = 1'b1;
        fl_init_done = 1'b0;
        #1;
        chk_all_zero("t6_async_reset");
        fl_alloc_ack = 1'b1;
        fl_alloc_id  = 8'h99;
        tick();
        tick();
        chk_all_zero("t6_reset_held");
        fl_alloc_ack = 1'b0;
        fl_alloc_id  = 8'h00;
        rst          = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (fl_alloc_req || fl_dealloc_req || (|cli_alloc_ack) || (|cli_dealloc_ack)) bad++;
        end
        chk("t6_no_stale_ack", 32'(bad), 32'd0);
        chk("t6_busy_init", 32'(busy), 32'd1);
        cli_alloc_req = 4'b0000;
        fl_init_done  = 1'b1;
        tick();
        tick();
        chk("t6_idle", 32'({busy, err_spurious}), 32'd0);

        // Step 4: mixed classes alternate, alloc first after reset.
        cli_alloc_req   = 4'b1010;
        cli_dealloc_req = 4'b1100;
        e = '{cls: 1'b0, idx: 1, id: 8'h41}; sb.push_back(e);
        e = '{cls: 1'b1, idx: 2, id: 8'h3C}; sb.push_back(e);
        e = '{cls: 1'b0, idx: 3, id: 8'h43}; sb.push_back(e);
        e = '{cls: 1'b1, idx: 3, id: 8'hA5}; sb.push_back(e);
        fl_serve(1'b0, 8'h41, 2, "t4_a1");
        fl_serve(1'b1, 8'h00, 2, "t4_d2");
        fl_serve(1'b0, 8'h43, 1, "t4_a3");
        fl_serve(1'b1, 8'h00, 1, "t4_d3");

        // Step 5: dealloc ack while idle sets the sticky error, no client response.
        chk("t5_err_pre", 32'(err_spurious), 32'd0);
        fl_dealloc_ack = 1'b1;
        tick();
        fl_dealloc_ack = 1'b0;
        chk("t5_err_set", 32'(err_spurious), 32'd1);
        tick();
        tick();
        tick();
        chk("t5_err_sticky", 32'(err_spurious), 32'd1);
        chk("t5_no_ack", 32'({cli_alloc_ack, cli_dealloc_ack, busy}), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
